imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 512, maximum number of instruction words accepted per load.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port s_valid  input  1  host byte-stream valid.
REQ-005 SHALL have port s_data  input  8  host byte.
REQ-006 SHALL have port s_ready  output  1  loader accepts byte; transfer occurs when s_valid and s_ready are both high at a clock edge.
REQ-007 SHALL have port load_req  input  1  restart request; honoured only in DONE.
REQ-008 SHALL have port addr_ext  output  32  instruction-memory external byte address.
REQ-009 SHALL have port wen_ext  output  1  instruction-memory external write enable.
REQ-010 SHALL have port ren_ext  output  1  instruction-memory external read enable; constant 0.
REQ-011 SHALL have port wdata_ext  output  32  instruction word to write.
REQ-012 SHALL have port cpu_enable  output  1  drives the CPU enable input.
REQ-013 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-014 SHALL implement FSM states HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR.
REQ-015 SHALL drive s_ready=1 only in HDR0, HDR1, DATA, CHK.
REQ-016 HDR0: accepted byte -> count[15:8], go HDR1; HDR1: accepted byte -> count[7:0].
REQ-017 After HDR1: count>MAX_WORDS -> ERR; count=0 -> CHK (macro defined) or DONE (macro undefined); else DATA with word index 0, byte index 0.
REQ-018 DATA SHALL assemble words big-endian: first byte -> [31:24], fourth byte -> [7:0]; after the fourth accepted byte go WRITE.
REQ-019 WRITE SHALL last exactly one cycle with wen_ext=1, wdata_ext=assembled word, addr_ext=index*4; index increments; index==count -> CHK/DONE per REQ-017, else DATA.
REQ-020 wen_ext SHALL be 0 in every state other than WRITE; addr_ext and wdata_ext hold last value outside WRITE.
REQ-021 Bytes with s_valid low SHALL be ignored without timeout; gaps of any length permitted.
REQ-022 DONE: cpu_enable=1, done=1, held until rst or load_req.
REQ-023 load_req in DONE SHALL drop cpu_enable the next cycle and enter HDR0, clearing count, index, checksum.
REQ-024 ERR: err=1, cpu_enable=0, s_ready=0, sticky until rst; load_req ignored.
REQ-025 busy SHALL be 1 in HDR1, DATA, WRITE, CHK, and in HDR0 once any byte of current load accepted (i.e., never in idle HDR0, DONE, ERR).

Reset
REQ-026 rst=1 at a clock edge SHALL force HDR0, count/index/checksum=0, addr_ext=0, wdata_ext=0, wen_ext=0, s_ready=1 next cycle, cpu_enable=0, busy=0, done=0, err=0, regardless of current state.
REQ-027 A reset mid-load SHALL abandon the partial word with no write issued.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: running XOR of every accepted header and data byte; CHK accepts one byte; equal -> DONE, unequal -> ERR.
REQ-029 LOADER_CHECKSUM_EN undefined: no checksum logic, CHK unreachable, last WRITE (or count=0) goes directly to DONE.

Verification
REQ-030 Macro on, bytes 00 01 DE AD BE EF 23 -> single wen_ext pulse addr 0x0 wdata 0xDEADBEEF, then done=1, cpu_enable=1.
REQ-031 Header 02 01 (513>512) -> err=1 after second byte, s_ready=0, no wen_ext pulse, cpu_enable stays 0.
REQ-032 Count 3, s_valid toggled every other cycle -> exactly three wen_ext pulses at addr 0x0, 0x4, 0x8 with correct words.
REQ-033 Macro on, REQ-030 stream with checksum 0x24 -> err=1, cpu_enable=0; macro off, stream without checksum byte -> done=1.
REQ-034 rst asserted after 2 data bytes -> all outputs at reset values next cycle, no write; subsequent full REQ-030 load succeeds.
REQ-035 Count 0 (macro on, checksum 0x00) -> done=1 with zero writes; then load_req -> cpu_enable=0 next cycle, state HDR0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit big-endian word count, then big-endian
// 32-bit words written to sequential addresses. Optional checksum stage: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        load_req,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = CHK;

  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  localparam state_t LAST_ST = DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic        s_ready_q, busy_q, done_q, err_q, cpu_en_q;
  logic        accept_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign accept_s = s_valid & s_ready_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      HDR0: begin
        if (accept_s) begin
          count_d = {s_data, count_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_upd(csum_q, s_data);
`endif
          state_d = HDR1;
        end else begin
          state_d = HDR0;
        end
      end
      HDR1: begin
        if (accept_s) begin
          count_d = {count_q[15:8], s_data};
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_upd(csum_q, s_data);
`endif
          index_d = 16'd0;
          bidx_d  = 2'd0;
          if (count_d > MAX_W) begin
            state_d = ERR;
          end else if (count_d == 16'd0) begin
            state_d = LAST_ST;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = HDR1;
        end
      end
      DATA: begin
        if (accept_s) begin
          word_d = {word_q[23:0], s_data};
          bidx_d = bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_upd(csum_q, s_data);
`endif
          if (bidx_q == 2'd3) begin
            wen_d   = 1'b1;
            wdata_d = word_d;
            addr_d  = {14'd0, index_q, 2'b00};
            state_d = WRITE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      WRITE: begin
        index_d = index_q + 16'd1;
        if (index_d == count_q) begin
          state_d = LAST_ST;
        end else begin
          state_d = DATA;
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept_s) begin
          state_d = (s_data == csum_q) ? DONE : ERR;
        end else begin
          state_d = CHK;
        end
`else
        state_d = ERR;
`endif
      end
      DONE: begin
        if (load_req) begin
          state_d = HDR0;
          count_d = 16'd0;
          index_d = 16'd0;
          bidx_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end else begin
          state_d = DONE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR0;
      count_q <= 16'd0;
      index_q <= 16'd0;
      bidx_q  <= 2'd0;
      word_q  <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Status flags decoded from the upcoming state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_en_q  <= 1'b0;
    end else begin
      s_ready_q <= (state_d == HDR0) || (state_d == HDR1) ||
                   (state_d == DATA) || (state_d == CHK);
      busy_q    <= (state_d == HDR1) || (state_d == DATA) ||
                   (state_d == WRITE) || (state_d == CHK);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERR);
      cpu_en_q  <= (state_d == DONE);
    end
  end

  assign s_ready    = s_ready_q;
  assign addr_ext   = addr_q;
  assign wen_ext    = wen_q;
  assign ren_ext    = 1'b0;
  assign wdata_ext  = wdata_q;
  assign cpu_enable = cpu_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by a negedge monitor; status flags are checked with directed expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        load_req;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        err;

  int          total = 0;
  int          bad = 0;
  int          writes = 0;
  int          w0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [7:0]  tb_csum;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(512)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_req(load_req), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every wen_ext cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr_ext, wdata_ext);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", addr_ext, e[63:32]);
        chk("write_data", wdata_ext, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int tries;
    tries = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && tries < 100) begin
      tick();
      tries++;
    end
    if (tries >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got s_ready %b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_data  = 8'h00;
    tb_csum = tb_csum ^ b;
    if (gap) tick();
  endtask

  task automatic send_hdr(input logic [15:0] cnt, input bit gap);
    tb_csum = 8'h00;
    send(cnt[15:8], gap);
    send(cnt[7:0], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send(w[31:24], gap);
    send(w[23:16], gap);
    send(w[15:8], gap);
    send(w[7:0], gap);
  endtask

  task automatic send_sum();
`ifdef LOADER_CHECKSUM_EN
    send(tb_csum, 1'b0);
`endif
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got done %b err %b expected one set", name, done, err);
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    load_req = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_enable}, 32'd0);
    chk("rst_addr", addr_ext, 32'd0);
    chk("rst_wdata", wdata_ext, 32'd0);
    chk("rst_wen", {31'd0, wen_ext}, 32'd0);
    chk("rst_ren", {31'd0, ren_ext}, 32'd0);
    rst = 1'b0;
    tick();

    // Single word load.
    w0 = writes;
    send_hdr(16'd1, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
    send_sum();
    wait_end("one_word");
    chk("one_done", {31'd0, done}, 32'd1);
    chk("one_cpu_en", {31'd0, cpu_enable}, 32'd1);
    chk("one_err", {31'd0, err}, 32'd0);
    chk("one_busy", {31'd0, busy}, 32'd0);
    chk("one_s_ready", {31'd0, s_ready}, 32'd0);
    chk("one_writes", writes - w0, 32'd1);
    pulse_load_req();
    chk("reload_cpu_en", {31'd0, cpu_enable}, 32'd0);
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_s_ready", {31'd0, s_ready}, 32'd1);
    chk("reload_busy", {31'd0, busy}, 32'd0);

    // Three words with s_valid toggling every other cycle.
    w0 = writes;
    send_hdr(16'd3, 1'b1);
    chk("three_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({32'h0000_0000, 32'h1122_3344});
    exp_q.push_back({32'h0000_0004, 32'h5566_7788});
    exp_q.push_back({32'h0000_0008, 32'h99AA_BBCC});
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    send_word(32'h99AA_BBCC, 1'b1);
    send_sum();
    wait_end("three");
    chk("three_done", {31'd0, done}, 32'd1);
    chk("three_writes", writes - w0, 32'd3);
    pulse_load_req();

    // Wrong checksum (macro on) or plain stream without checksum byte (macro off).
    send_hdr(16'd1, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h24, 1'b0);
    wait_end("badsum");
    chk("badsum_err", {31'd0, err}, 32'd1);
    chk("badsum_cpu_en", {31'd0, cpu_enable}, 32'd0);
    chk("badsum_s_ready", {31'd0, s_ready}, 32'd0);
`else
    wait_end("nosum");
    chk("nosum_done", {31'd0, done}, 32'd1);
    chk("nosum_cpu_en", {31'd0, cpu_enable}, 32'd1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", {31'd0, err}, 32'd0);

    // Reset after two data bytes abandons the partial word.
    w0 = writes;
    send_hdr(16'd1, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_s_ready", {31'd0, s_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_addr", addr_ext, 32'd0);
    chk("mid_wdata", wdata_ext, 32'd0);
    chk("mid_wen", {31'd0, wen_ext}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_cpu_en", {31'd0, cpu_enable}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_writes", writes - w0, 32'd0);
    send_hdr(16'd1, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
    send_sum();
    wait_end("after_rst");
    chk("after_rst_done", {31'd0, done}, 32'd1);
    chk("after_rst_writes", writes - w0, 32'd1);
    pulse_load_req();

    // Zero-length load, then restart.
    w0 = writes;
    send_hdr(16'd0, 1'b0);
    send_sum();
    wait_end("zero");
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_writes", writes - w0, 32'd0);
    pulse_load_req();
    chk("zero_reload_cpu_en", {31'd0, cpu_enable}, 32'd0);
    chk("zero_reload_s_ready", {31'd0, s_ready}, 32'd1);

    // Largest permitted load.
    w0 = writes;
    send_hdr(16'd512, 1'b0);
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back({32'(i * 4), 32'hA500_0000 | 32'(i)});
      send_word(32'hA500_0000 | 32'(i), 1'b0);
    end
    send_sum();
    wait_end("max");
    chk("max_done", {31'd0, done}, 32'd1);
    chk("max_err", {31'd0, err}, 32'd0);
    chk("max_writes", writes - w0, 32'd512);
    pulse_load_req();

    // One over the limit: error right after the second header byte.
    w0 = writes;
    send_hdr(16'd513, 1'b0);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_s_ready", {31'd0, s_ready}, 32'd0);
    chk("over_cpu_en", {31'd0, cpu_enable}, 32'd0);
    chk("over_busy", {31'd0, busy}, 32'd0);
    pulse_load_req();
    tick();
    chk("over_sticky_err", {31'd0, err}, 32'd1);
    chk("over_sticky_done", {31'd0, done}, 32'd0);
    chk("over_writes", writes - w0, 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
